// File: rtl/uart_tx_pkg.sv
// Shared encodings for the UART transmit frame controller.
// UART_TX_TWO_STOP_EN adds a second stop-bit state to the FSM.
package uart_tx_pkg;

  localparam int DATA_BITS = 8;

`ifdef UART_TX_TWO_STOP_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_STOP2  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`endif

  typedef enum logic [1:0] {
    SEL_START = 2'b00,
    SEL_STOP  = 2'b01,
    SEL_DATA  = 2'b10,
    SEL_PAR   = 2'b11
  } sel_t;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity for one data byte: even (par_typ=0) or odd (par_typ=1).
module uart_parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  assign parity = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start / data / optional parity / stop sequencing.
// UART_TX_TWO_STOP_EN appends a second stop bit (STOP2 state).
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_BITS
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic                  ser_en,
  output logic                  Busy,
  output logic                  TX_OUT
);

  state_t state;
  state_t next_state;
  sel_t   sel;
  logic   par_bit;
  logic   par_lat;
  logic   pen_lat;
  logic   tx_mux;
  logic   accept;

  assign accept = (state == ST_IDLE) && Data_Valid;

  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .parity  (par_bit)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Parity options are frozen at accept so mid-frame input changes cannot leak in.
  always_ff @(posedge CLK) begin
    if (RST) begin
      par_lat <= 1'b0;
      pen_lat <= 1'b0;
    end else if (accept) begin
      par_lat <= par_bit;
      pen_lat <= PAR_EN;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (Data_Valid) next_state = ST_START;
      ST_START:  next_state = ST_DATA;
      ST_DATA:   if (ser_done) next_state = pen_lat ? ST_PARITY : ST_STOP;
      ST_PARITY: next_state = ST_STOP;
`ifdef UART_TX_TWO_STOP_EN
      ST_STOP:   next_state = ST_STOP2;
      ST_STOP2:  next_state = ST_IDLE;
`else
      ST_STOP:   next_state = ST_IDLE;
`endif
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy   = (state != ST_IDLE);
    ser_en = (state == ST_DATA);
    sel    = SEL_STOP;
    case (state)
      ST_START:  sel = SEL_START;
      ST_DATA:   sel = SEL_DATA;
      ST_PARITY: sel = SEL_PAR;
      default:   sel = SEL_STOP;
    endcase
  end

  always_comb begin
    tx_mux = 1'b1;
    case (sel)
      SEL_START: tx_mux = 1'b0;
      SEL_STOP:  tx_mux = 1'b1;
      SEL_DATA:  tx_mux = ser_data;
      SEL_PAR:   tx_mux = par_lat;
      default:   tx_mux = 1'b1;
    endcase
  end

  // Registered line output: the whole frame trails the state by one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      TX_OUT <= 1'b1;
    end else begin
      TX_OUT <= tx_mux;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl with a serializer stand-in and a frame-level line model.
// Honours UART_TX_TWO_STOP_EN for the expected frame length.
module tb_uart_tx_ctrl;

`ifdef UART_TX_TWO_STOP_EN
  localparam int EXTRA_STOP = 1;
`else
  localparam int EXTRA_STOP = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       ser_done;
  logic       ser_data;
  logic       ser_en;
  logic       Busy;
  logic       TX_OUT;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_done   (ser_done),
    .ser_data   (ser_data),
    .ser_en     (ser_en),
    .Busy       (Busy),
    .TX_OUT     (TX_OUT)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Serializer stand-in: loads on accept, shifts LSB-first while enabled, flags its 8th bit.
  logic [7:0] sh;
  logic [2:0] cnt;
  logic       noise = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      sh  <= 8'h00;
      cnt <= 3'd0;
    end else if (Data_Valid && !Busy) begin
      sh  <= P_DATA;
      cnt <= 3'd0;
    end else if (ser_en) begin
      sh  <= sh >> 1;
      cnt <= cnt + 3'd1;
    end else begin
      cnt <= 3'd0;
    end
  end

  assign ser_data = sh[0];
  assign ser_done = (cnt == 3'd7) | noise;

  // Frame-level reference: a queue of line bits per accepted byte plus a busy countdown.
  bit q_line[$];
  int busy_left = 0;
  int frame_len = 0;
  bit exp_tx    = 1'b1;

  always @(posedge CLK) begin
    if (RST) begin
      q_line.delete();
      busy_left = 0;
      exp_tx    = 1'b1;
    end else begin
      exp_tx = (q_line.size() > 0) ? q_line.pop_front() : 1'b1;
      if (busy_left == 0) begin
        if (Data_Valid) begin
          int ones;
          ones = 0;
          q_line.push_back(1'b0);
          for (int i = 0; i < 8; i++) begin
            q_line.push_back(P_DATA[i]);
            ones += int'(P_DATA[i]);
          end
          if (PAR_EN) q_line.push_back(((ones % 2) == 1) ^ PAR_TYP);
          q_line.push_back(1'b1);
          if (EXTRA_STOP == 1) q_line.push_back(1'b1);
          frame_len = q_line.size();
          busy_left = frame_len;
        end
      end else begin
        busy_left--;
      end
    end
  end

  function automatic bit model_in_data();
    int pos;
    pos = frame_len - busy_left;
    return (busy_left > 0) && (pos >= 1) && (pos <= 8);
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      check("tx_line", TX_OUT, exp_tx);
      check("busy", Busy, busy_left > 0);
      check("ser_en", ser_en, model_in_data());
    end
  end

  // Starts at a negedge with the DUT idle; captures 12 line bits from the start bit on.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                            input bit toggle_typ, output logic [11:0] line,
                            output int busy_n, output int sen_n);
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    busy_n = 0;
    sen_n  = 0;
    line   = '0;
    for (int i = 0; i < 14; i++) begin
      busy_n += int'(Busy);
      sen_n  += int'(ser_en);
      if (i == 3) begin
        Data_Valid = 1'b1;
        P_DATA     = 8'h99;
      end
      if (i == 4) Data_Valid = 1'b0;
      if (toggle_typ && i == 5) begin
        PAR_TYP = ~PAR_TYP;
        PAR_EN  = ~PAR_EN;
      end
      @(negedge CLK);
      if (i < 12) line[i] = TX_OUT;
    end
  endtask

  initial begin
    logic [11:0] line;
    int busy_n, sen_n, rises, idle_n;
    bit prev;

    RST = 1'b1; P_DATA = 8'h00; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_tx", TX_OUT, 1'b1);
    check("rst_busy", Busy, 1'b0);
    check("rst_ser_en", ser_en, 1'b0);
    RST = 1'b0;
    chk_en = 1'b1;
    @(negedge CLK);

    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, line, busy_n, sen_n);
    check("a5_nopar_line", line, 12'hF4A);
    check("a5_nopar_busy", busy_n, 10 + EXTRA_STOP);
    check("a5_nopar_ser_en", sen_n, 8);

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, line, busy_n, sen_n);
    check("a5_even_line", line, 12'hD4A);
    check("a5_even_par", line[9], 1'b0);
    check("a5_even_busy", busy_n, 11 + EXTRA_STOP);

    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, line, busy_n, sen_n);
    check("a5_odd_par", line[9], 1'b1);
    check("a5_odd_busy", busy_n, 11 + EXTRA_STOP);

    send_frame(8'h07, 1'b1, 1'b0, 1'b1, line, busy_n, sen_n);
    check("07_even_toggle_par", line[9], 1'b1);
    check("07_even_toggle_busy", busy_n, 11 + EXTRA_STOP);
    check("07_ser_en", sen_n, 8);

    // Data_Valid held across two frames: exactly two frames, one idle cycle between.
    P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    prev = 1'b0; rises = 0; idle_n = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      if (i == 0) P_DATA = 8'hC3;
      if (i == 2 * (10 + EXTRA_STOP) + 1) Data_Valid = 1'b0;
      if (Busy && !prev) rises++;
      if (!Busy && i > 0 && i < 2 * (10 + EXTRA_STOP) + 1) idle_n++;
      prev = Busy;
    end
    check("b2b_frames", rises, 2);
    check("b2b_idle_gap", idle_n, 1);

    // Reset landing in the 4th data-bit cycle.
    P_DATA = 8'hE1; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (4) @(negedge CLK);
    check("pre_rst_ser_en", ser_en, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("midrst_tx", TX_OUT, 1'b1);
    check("midrst_busy", Busy, 1'b0);
    check("midrst_ser_en", ser_en, 1'b0);
    @(negedge CLK);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, line, busy_n, sen_n);
    check("55_line", line, 12'hEAA);
    check("55_busy", busy_n, 10 + EXTRA_STOP);

    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, line, busy_n, sen_n);
    check("ff_line", line, 12'hFFE);
    check("ff_busy", busy_n, 10 + EXTRA_STOP);

    // Random traffic, mid-frame option changes, stray ser_done and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      Data_Valid = ($urandom_range(0, 3) == 0);
      P_DATA     = 8'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
      noise      = ($urandom_range(0, 2) == 0) && !model_in_data();
      RST        = ($urandom_range(0, 249) == 0);
      @(negedge CLK);
    end
    noise = 1'b0; RST = 1'b0; Data_Valid = 1'b0;
    repeat (15) @(negedge CLK);
    check("final_idle_busy", Busy, 1'b0);
    check("final_idle_tx", TX_OUT, 1'b1);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
